// File: rtl/board_scanner_if.sv
// Board scanner bundle: start request, framebuffer read port and tile maps.
// Latency: pure wiring, no storage.
// Backpressure: none; the framebuffer answers one cycle after every read strobe.
interface board_scanner_if;
    logic        start;
    logic        rd_en;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic [2:0]  rd_data;
    logic [63:0] flag_map;
    logic [63:0] step_map;
    logic [63:0] mine_map;
    logic        busy;
    logic        done;

    // Scanner side: drives the read port and publishes the maps.
    modport master (
        input  start, rd_data,
        output rd_en, rd_x, rd_y, flag_map, step_map, mine_map, busy, done
    );

    // Host/framebuffer side.
    modport slave (
        output start, rd_data,
        input  rd_en, rd_x, rd_y, flag_map, step_map, mine_map, busy, done
    );
endinterface

// File: rtl/board_scanner.sv
// Samples one pixel per tile of an 8x8 board and classifies it into flag/revealed/mine maps.
// Latency: start seen in IDLE at cycle T -> done pulse at T+129 (2 cycles per tile + DONE).
// Backpressure: none; start is ignored while a scan runs. BOARD_SCAN_CENTER_EN samples tile centres.
module board_scanner (
    input  logic          clk,
    input  logic          reset,
    board_scanner_if.master bus
);
    localparam logic [7:0] TILE_W = 8'd19;
    localparam logic [6:0] TILE_H = 7'd14;
`ifdef BOARD_SCAN_CENTER_EN
    localparam logic [7:0] OFF_X  = 8'd9;
    localparam logic [6:0] OFF_Y  = 7'd7;
`else
    localparam logic [7:0] OFF_X  = 8'd0;
    localparam logic [6:0] OFF_Y  = 7'd0;
`endif

    typedef enum logic [1:0] {IDLE, READ, CAP, DONE} state_t;

    state_t      state;
    logic [5:0]  idx;
    logic [7:0]  org_x;
    logic [6:0]  org_y;
    logic [63:0] shadow_flag, shadow_step, shadow_mine;
    logic [63:0] flag_q, step_q, mine_q;
    logic        rd_en_q, busy_q, done_q;
    logic [7:0]  rd_x_q;
    logic [6:0]  rd_y_q;

    logic [7:0]  nxt_org_x;
    logic [6:0]  nxt_org_y;
    logic [63:0] nxt_flag, nxt_step, nxt_mine;

    // Origin of the following tile: step right one tile, or wrap to the next row after column 7.
    always_comb begin
        nxt_org_x = org_x + TILE_W;
        nxt_org_y = org_y;
        if (idx[2:0] == 3'd7) begin
            nxt_org_x = 8'd0;
            nxt_org_y = org_y + TILE_H;
        end
    end

    // Shadow maps with the pixel currently on rd_data classified into bit idx.
    always_comb begin
        nxt_flag      = shadow_flag;
        nxt_step      = shadow_step;
        nxt_mine      = shadow_mine;
        nxt_flag[idx] = (bus.rd_data == 3'b010);
        nxt_step[idx] = (bus.rd_data == 3'b111);
        nxt_mine[idx] = (bus.rd_data == 3'b100);
    end

    // Scan sequencer with registered read strobe, coordinates, status and maps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= 6'd0;
            org_x       <= 8'd0;
            org_y       <= 7'd0;
            shadow_flag <= 64'd0;
            shadow_step <= 64'd0;
            shadow_mine <= 64'd0;
            flag_q      <= 64'd0;
            step_q      <= 64'd0;
            mine_q      <= 64'd0;
            rd_en_q     <= 1'b0;
            rd_x_q      <= 8'd0;
            rd_y_q      <= 7'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= READ;
                        idx     <= 6'd0;
                        org_x   <= 8'd0;
                        org_y   <= 7'd0;
                        rd_en_q <= 1'b1;
                        rd_x_q  <= OFF_X;
                        rd_y_q  <= OFF_Y;
                        busy_q  <= 1'b1;
                    end
                end
                READ: begin
                    state   <= CAP;
                    rd_en_q <= 1'b0;
                    rd_x_q  <= 8'd0;
                    rd_y_q  <= 7'd0;
                end
                CAP: begin
                    shadow_flag <= nxt_flag;
                    shadow_step <= nxt_step;
                    shadow_mine <= nxt_mine;
                    if (idx == 6'd63) begin
                        // Last tile's classification goes straight into the published maps.
                        state  <= DONE;
                        flag_q <= nxt_flag;
                        step_q <= nxt_step;
                        mine_q <= nxt_mine;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        state   <= READ;
                        idx     <= idx + 6'd1;
                        org_x   <= nxt_org_x;
                        org_y   <= nxt_org_y;
                        rd_en_q <= 1'b1;
                        rd_x_q  <= nxt_org_x + OFF_X;
                        rd_y_q  <= nxt_org_y + OFF_Y;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en    = rd_en_q;
    assign bus.rd_x     = rd_x_q;
    assign bus.rd_y     = rd_y_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.flag_map = flag_q;
    assign bus.step_map = step_q;
    assign bus.mine_map = mine_q;
endmodule

// File: tb/tb_board_scanner.sv
// Testbench for board_scanner: framebuffer model driven from a per-tile colour table,
// reference maps computed from the colour table, directed scan scenarios with random colours.
// Honours BOARD_SCAN_CENTER_EN for the expected sample points.
module tb_board_scanner;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    board_scanner_if bus();

    board_scanner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef BOARD_SCAN_CENTER_EN
    localparam int OFF_X = 9;
    localparam int OFF_Y = 7;
`else
    localparam int OFF_X = 0;
    localparam int OFF_Y = 0;
`endif

    int total  = 0;
    int passed = 0;

    logic [2:0]  colour [64];
    logic [63:0] old_f, old_s, old_m;
    logic [63:0] exp_f, exp_s, exp_m;

    int         rd_cnt  = 0;
    bit         prev_rd = 1'b0;
    logic [7:0] t9_x, t63_x;
    logic [6:0] t9_y, t63_y;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference maps straight from the colour rules.
    task automatic model(output logic [63:0] f, output logic [63:0] s, output logic [63:0] m);
        f = '0; s = '0; m = '0;
        for (int i = 0; i < 64; i++) begin
            if (colour[i] == 3'd2) f[i] = 1'b1;
            if (colour[i] == 3'd7) s[i] = 1'b1;
            if (colour[i] == 3'd4) m[i] = 1'b1;
        end
    endtask

    task automatic randomize_colours();
        for (int i = 0; i < 64; i++) colour[i] = 3'($urandom_range(0, 7));
    endtask

    // Framebuffer model and read-port monitor, evaluated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (reset !== 1'b1) begin
            rd_cnt  = 0;
            prev_rd = 1'b0;
        end
        if (bus.rd_en === 1'b1) begin
            check("rd_x", 64'(bus.rd_x), 64'((rd_cnt % 8) * 19 + OFF_X));
            check("rd_y", 64'(bus.rd_y), 64'((rd_cnt / 8) * 14 + OFF_Y));
            if (rd_cnt == 9)  begin t9_x  = bus.rd_x; t9_y  = bus.rd_y; end
            if (rd_cnt == 63) begin t63_x = bus.rd_x; t63_y = bus.rd_y; end
            if (bus.rd_x < 8'd152 && bus.rd_y < 7'd112)
                bus.rd_data = colour[(int'(bus.rd_y) / 14) * 8 + int'(bus.rd_x) / 19];
            else
                bus.rd_data = 3'd0;
            rd_cnt  = (rd_cnt + 1) % 64;
            prev_rd = 1'b1;
        end else begin
            check("rd_idle_xy", 64'({bus.rd_x, bus.rd_y}), 64'd0);
            // Data is only guaranteed the cycle after a read; scramble it otherwise.
            if (!prev_rd) bus.rd_data = 3'($urandom_range(0, 7));
            prev_rd = 1'b0;
        end
    end

    // Advance negedge by negedge until done; maps must hold old values meanwhile. k=-1 on timeout.
    task automatic wait_done(input int k0, input int limit, input bit drop_start,
                             input int pulse_k, output int k);
        k = k0;
        while (k < limit) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("first_rd_en", 64'(bus.rd_en), 64'd1);
                check("first_busy", 64'(bus.busy), 64'd1);
                if (drop_start) bus.start = 1'b0;
            end
            if (pulse_k > 0 && k == pulse_k)     bus.start = 1'b1;
            if (pulse_k > 0 && k == pulse_k + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) return;
            check("hold_flag", bus.flag_map, old_f);
            check("hold_step", bus.step_map, old_s);
            check("hold_mine", bus.mine_map, old_m);
        end
        k = -1;
    endtask

    task automatic check_maps(input string tag);
        check({tag, "_flag"}, bus.flag_map, exp_f);
        check({tag, "_step"}, bus.step_map, exp_s);
        check({tag, "_mine"}, bus.mine_map, exp_m);
    endtask

    initial begin
        int k;
        int pulses;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.rd_data = 3'd0;
        for (int i = 0; i < 64; i++) colour[i] = 3'd0;
        old_f = '0; old_s = '0; old_m = '0;
        t9_x = '0; t9_y = '0; t63_x = '0; t63_y = '0;

        // Reset state and quiet idle.
        repeat (3) @(negedge clk);
        check("rst_rd_en", 64'(bus.rd_en), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) pulses++;
        end
        check("idle_quiet", 64'(pulses), 64'd0);
        exp_f = '0; exp_s = '0; exp_m = '0;
        check_maps("idle_maps");

        // Tile 0 green, tile 63 white, everything else black.
        colour[0] = 3'b010; colour[63] = 3'b111;
        bus.start = 1'b1;
        wait_done(0, 300, 1'b1, 0, k);
        check("a_done_at", 64'(k), 64'd129);
        check("a_flag_lit", bus.flag_map, 64'h1);
        check("a_step_lit", bus.step_map, 64'h8000_0000_0000_0000);
        check("a_mine_lit", bus.mine_map, 64'h0);
        @(negedge clk);
        check("a_done_1cyc", 64'(bus.done), 64'd0);
        check("a_busy_after", 64'(bus.busy), 64'd0);
        old_f = bus.flag_map; old_s = bus.step_map; old_m = bus.mine_map;
        old_f = 64'h1; old_s = 64'h8000_0000_0000_0000; old_m = 64'h0;

        // Random board with a red tile 9.
        randomize_colours();
        colour[9] = 3'b100;
        model(exp_f, exp_s, exp_m);
        bus.start = 1'b1;
        wait_done(0, 300, 1'b1, 0, k);
        check("b_done_at", 64'(k), 64'd129);
        check_maps("b");
        check("b_mine9", 64'(bus.mine_map[9]), 64'd1);
        check("b_t9_x", 64'(t9_x), 64'(19 + OFF_X));
        check("b_t9_y", 64'(t9_y), 64'(14 + OFF_Y));
        old_f = exp_f; old_s = exp_s; old_m = exp_m;
        @(negedge clk);

        // Reset mid-scan at T+60: abort, no done, maps cleared.
        randomize_colours();
        bus.start = 1'b1;
        wait_done(0, 60, 1'b1, 0, k);
        check("c_no_done_early", 64'(k), 64'hFFFF_FFFF_FFFF_FFFF);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("c_busy", 64'(bus.busy), 64'd0);
        check("c_rd_en", 64'(bus.rd_en), 64'd0);
        check("c_done", 64'(bus.done), 64'd0);
        exp_f = '0; exp_s = '0; exp_m = '0;
        check_maps("c");
        pulses = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.rd_en === 1'b1) pulses++;
        end
        check("c_stays_idle", 64'(pulses), 64'd0);
        old_f = '0; old_s = '0; old_m = '0;

        // Second start pulse at T+40 is ignored.
        randomize_colours();
        model(exp_f, exp_s, exp_m);
        bus.start = 1'b1;
        wait_done(0, 300, 1'b1, 40, k);
        check("d_done_at", 64'(k), 64'd129);
        check_maps("d");
        pulses = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.rd_en === 1'b1) pulses++;
        end
        check("d_single_scan", 64'(pulses), 64'd0);
        old_f = exp_f; old_s = exp_s; old_m = exp_m;

        // Start held high: back-to-back scans with one idle cycle between.
        randomize_colours();
        model(exp_f, exp_s, exp_m);
        t63_x = '0; t63_y = '0;
        bus.start = 1'b1;
        wait_done(0, 300, 1'b0, 0, k);
        check("e_done1_at", 64'(k), 64'd129);
        check_maps("e1");
        old_f = exp_f; old_s = exp_s; old_m = exp_m;
        randomize_colours();
        model(exp_f, exp_s, exp_m);
        @(negedge clk);
        check("e_gap_rd_en", 64'(bus.rd_en), 64'd0);
        check("e_gap_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("e_restart_rd_en", 64'(bus.rd_en), 64'd1);
        wait_done(131, 500, 1'b0, 0, k);
        bus.start = 1'b0;
        check("e_done2_at", 64'(k), 64'd259);
        check_maps("e2");
        check("e_t63_x", 64'(t63_x), 64'(133 + OFF_X));
        check("e_t63_y", 64'(t63_y), 64'(98 + OFF_Y));
        repeat (3) @(negedge clk);
        check("e_end_busy", 64'(bus.busy), 64'd0);
        check("e_end_rd_en", 64'(bus.rd_en), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/board_scanner.md
BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-003 SHALL have port start, input, 1, level request to begin a scan, sampled only in IDLE.
REQ-004 SHALL have port rd_en, output, 1, framebuffer read strobe.
REQ-005 SHALL have port rd_x, output, 8, framebuffer pixel column.
REQ-006 SHALL have port rd_y, output, 7, framebuffer pixel row.
REQ-007 SHALL have port rd_data, input, 3, pixel colour, valid exactly one cycle after rd_en.
REQ-008 SHALL have port flag_map, output, 64, one bit per tile: tile shows flag.
REQ-009 SHALL have port step_map, output, 64, one bit per tile: tile shows revealed.
REQ-010 SHALL have port mine_map, output, 64, one bit per tile: tile shows mine.
REQ-011 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when the maps update.

Function
REQ-013 SHALL scan an 8x8 board of 19x14-pixel tiles on a 160x120 framebuffer; tile i has col = i mod 8, row = i div 8, origin (col*19, row*14); i runs 0..63.
REQ-014 SHALL derive tile origins with incremental adders (x += 19 per column, wrap to 0 after col 7 with y += 14); no multipliers.
REQ-015 SHALL implement FSM states IDLE, READ, CAP, DONE.
REQ-016 IDLE: start=1 -> READ with i=0; otherwise stay; start in any other state is ignored.
REQ-017 READ: rd_en=1, rd_x/rd_y = sample point of tile i; next state CAP.
REQ-018 CAP: rd_data classified into shadow bit i; i==63 -> DONE, else i+1 -> READ.
REQ-019 Classification: 3'b010 -> flag; 3'b111 -> revealed; 3'b100 -> mine; any other value -> all three bits 0.
REQ-020 DONE: shadow copied to flag_map/step_map/mine_map on the edge entering DONE; done=1 for that single cycle; next state IDLE.
REQ-021 Timing: start high in IDLE at cycle T -> first rd_en at T+1 -> done at T+129; 2 cycles per tile.
REQ-022 flag_map/step_map/mine_map SHALL hold the previous scan's values throughout a scan and change only on DONE entry.
REQ-023 busy=1 in READ and CAP, 0 in IDLE and DONE.
REQ-024 rd_en SHALL be 0 outside READ; rd_x/rd_y SHALL be 0 when rd_en=0.
REQ-025 rd_x SHALL never exceed 159 and rd_y SHALL never exceed 119 for any tile.
REQ-026 start held high continuously SHALL produce back-to-back scans, one IDLE cycle between DONE and the next READ.

Reset
REQ-027 reset=0 SHALL force IDLE, i=0, clear all maps and shadow bits, and drive rd_en, busy, done, rd_x, rd_y to 0.
REQ-028 reset asserted mid-scan SHALL abort the scan; no partial map update and no done pulse.

Configuration
REQ-029 Macro BOARD_SCAN_CENTER_EN defined: sample point = tile origin + (9,7), the tile centre; not defined: sample point = tile origin.
REQ-030 All timing, state, and classification rules SHALL be identical with and without BOARD_SCAN_CENTER_EN.

Verification
REQ-031 Reset then idle 10 cycles -> all maps 0, busy=0, done=0, rd_en never high.
REQ-032 Framebuffer model with tile 0 green and tile 63 white, start pulse at T -> done at T+129, flag_map=64'h1, step_map=64'h8000_0000_0000_0000, mine_map=0.
REQ-033 Tile 9 origin red, macro off -> rd_x=19, rd_y=14 on its read, mine_map bit 9=1. Macro on -> rd_x=28, rd_y=21.
REQ-034 reset=0 at T+60 of a scan -> no done pulse, maps stay 0, FSM in IDLE the next cycle.
REQ-035 start pulsed again at T+40 -> ignored, exactly one done at T+129. Maps stay at old values until T+129.
REQ-036 start held high -> done at T+129 and T+259. Tile 63 read at rd_x=133, rd_y=98 (macro off).
